// File: rtl/merc16_pkg.sv
// ============================================================================
// merc16_pkg -- shared width, reset PC and fetch FSM encodings
// Revision: 1.0
// ============================================================================
`default_nettype none

package merc16_pkg;

    localparam int          WIDTH            = 16;
    localparam logic [15:0] RESET_PC_DEFAULT = 16'h0000;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FETCH   = 2'd1,
        ST_HOLD    = 2'd2,
        ST_DISCARD = 2'd3
    } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/program_counter.sv
// ============================================================================
// program_counter -- PC register with load (priority) and wrapping increment
// Revision: 1.0
// ============================================================================
`default_nettype none

module program_counter
    import merc16_pkg::*;
#(
    parameter int               WIDTH    = merc16_pkg::WIDTH,
    parameter logic [WIDTH-1:0] RESET_PC = merc16_pkg::RESET_PC_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] target,
    input  logic             inc,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_next
);

    // The increment wraps naturally through the fixed-width add.
    always_comb begin
        pc_next = pc;
        if (load) begin
            pc_next = target;
        end else if (inc) begin
            pc_next = pc + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_next;
        end
    end

endmodule

`default_nettype wire

// File: rtl/instruction_fetch.sv
// ============================================================================
// instruction_fetch -- fetch FSM with instruction register and branch redirect
// Revision: 1.0
// ============================================================================
`default_nettype none

module instruction_fetch
    import merc16_pkg::*;
#(
    parameter int               WIDTH    = merc16_pkg::WIDTH,
    parameter logic [WIDTH-1:0] RESET_PC = merc16_pkg::RESET_PC_DEFAULT
) (
    input  logic             Clock,
    input  logic             Reset_n,
    output logic             MemReq,
    output logic [WIDTH-1:0] MemAddr,
    input  logic             MemAck,
    input  logic [WIDTH-1:0] MemData,
    input  logic             BranchTaken,
    input  logic [WIDTH-1:0] BranchTarget,
    output logic [WIDTH-1:0] InstrOut,
    output logic [WIDTH-1:0] PcOut,
    output logic             InstrValid,
    input  logic             DecodeReady
);

    fetch_state_t     state;
    fetch_state_t     state_next;
    logic             pc_load;
    logic             pc_inc;
    logic             capture;
    logic             clear_valid;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_next;

    program_counter #(
        .WIDTH    (WIDTH),
        .RESET_PC (RESET_PC)
    ) u_program_counter (
        .clk     (Clock),
        .rst_n   (Reset_n),
        .load    (pc_load),
        .target  (BranchTarget),
        .inc     (pc_inc),
        .pc      (pc),
        .pc_next (pc_next)
    );

    always_comb begin
        state_next  = state;
        pc_load     = 1'b0;
        pc_inc      = 1'b0;
        capture     = 1'b0;
        clear_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                pc_load    = BranchTaken;
                state_next = ST_FETCH;
            end
            ST_FETCH: begin
                if (BranchTaken) begin
                    // An unacked request must still complete, so park in DISCARD.
                    pc_load    = 1'b1;
                    state_next = MemAck ? ST_FETCH : ST_DISCARD;
                end else if (MemAck) begin
                    capture    = 1'b1;
                    pc_inc     = 1'b1;
                    state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (BranchTaken) begin
                    pc_load     = 1'b1;
                    clear_valid = 1'b1;
                    state_next  = ST_FETCH;
                end else if (DecodeReady) begin
                    clear_valid = 1'b1;
                    state_next  = ST_FETCH;
                end
            end
            ST_DISCARD: begin
                pc_load = BranchTaken;
                if (MemAck) begin
                    state_next = ST_FETCH;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The request address follows the PC only when a new fetch begins,
    // so it stays on the old address while a discarded request drains.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            MemAddr <= RESET_PC;
        end else if (state_next == ST_FETCH) begin
            MemAddr <= pc_next;
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            InstrOut   <= '0;
            PcOut      <= '0;
            InstrValid <= 1'b0;
        end else if (capture) begin
            InstrOut   <= MemData;
            PcOut      <= pc;
            InstrValid <= 1'b1;
        end else if (clear_valid) begin
            InstrValid <= 1'b0;
        end
    end

    assign MemReq = (state == ST_FETCH) || (state == ST_DISCARD);

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch.sv
// ============================================================================
// tb_instruction_fetch -- directed self-checking bench for instruction_fetch
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_instruction_fetch;

    logic        Clock;
    logic        Reset_n;
    logic        MemReq;
    logic [15:0] MemAddr;
    logic        MemAck;
    logic [15:0] MemData;
    logic        BranchTaken;
    logic [15:0] BranchTarget;
    logic [15:0] InstrOut;
    logic [15:0] PcOut;
    logic        InstrValid;
    logic        DecodeReady;

    int total;
    int passed;

    instruction_fetch dut (
        .Clock        (Clock),
        .Reset_n      (Reset_n),
        .MemReq       (MemReq),
        .MemAddr      (MemAddr),
        .MemAck       (MemAck),
        .MemData      (MemData),
        .BranchTaken  (BranchTaken),
        .BranchTarget (BranchTarget),
        .InstrOut     (InstrOut),
        .PcOut        (PcOut),
        .InstrValid   (InstrValid),
        .DecodeReady  (DecodeReady)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge Clock);
        @(negedge Clock);
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    initial begin
        total        = 0;
        passed       = 0;
        Reset_n      = 1'b0;
        MemAck       = 1'b0;
        MemData      = 16'h0000;
        BranchTaken  = 1'b0;
        BranchTarget = 16'h0000;
        DecodeReady  = 1'b0;

        tick();
        tick();
        check("rst_memreq",  {15'd0, MemReq},     16'h0000);
        check("rst_memaddr", MemAddr,             16'h0000);
        check("rst_instr",   InstrOut,            16'h0000);
        check("rst_pcout",   PcOut,               16'h0000);
        check("rst_valid",   {15'd0, InstrValid}, 16'h0000);

        // First fetch after reset release.
        Reset_n = 1'b1;
        tick();
        check("idle_to_fetch_req",  {15'd0, MemReq}, 16'h0001);
        check("idle_to_fetch_addr", MemAddr,         16'h0000);

        MemAck = 1'b1; MemData = 16'h1234;
        tick();
        MemAck = 1'b0;
        check("f0_instr", InstrOut,            16'h1234);
        check("f0_pcout", PcOut,               16'h0000);
        check("f0_valid", {15'd0, InstrValid}, 16'h0001);
        check("f0_hold_req", {15'd0, MemReq},  16'h0000);

        // Decode stall for five cycles.
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_instr", InstrOut,            16'h1234);
            check("stall_pcout", PcOut,               16'h0000);
            check("stall_req",   {15'd0, MemReq},     16'h0000);
            check("stall_valid", {15'd0, InstrValid}, 16'h0001);
        end
        DecodeReady = 1'b1;
        tick();
        DecodeReady = 1'b0;
        check("accept_valid", {15'd0, InstrValid}, 16'h0000);
        check("accept_req",   {15'd0, MemReq},     16'h0001);
        check("accept_addr",  MemAddr,             16'h0001);

        // Sequential fetches at 1..4.
        for (int a = 1; a <= 4; a++) begin
            MemAck = 1'b1; MemData = 16'hA000 + 16'(a);
            tick();
            MemAck = 1'b0;
            check("seq_pcout", PcOut,    16'(a));
            check("seq_instr", InstrOut, 16'hA000 + 16'(a));
            DecodeReady = 1'b1;
            tick();
            DecodeReady = 1'b0;
        end
        check("seq_next_addr", MemAddr, 16'h0005);

        // Branch while request at 5 is outstanding; ack three cycles later.
        BranchTaken = 1'b1; BranchTarget = 16'h0040;
        tick();
        BranchTaken = 1'b0;
        check("disc_req",   {15'd0, MemReq}, 16'h0001);
        check("disc_addr0", MemAddr,         16'h0005);
        tick();
        check("disc_addr1", MemAddr,         16'h0005);
        tick();
        check("disc_addr2", MemAddr,         16'h0005);
        MemAck = 1'b1; MemData = 16'hDEAD;
        tick();
        MemAck = 1'b0;
        check("disc_drop_valid", {15'd0, InstrValid}, 16'h0000);
        check("disc_drop_instr", InstrOut,            16'hA004);
        check("disc_redir_req",  {15'd0, MemReq},     16'h0001);
        check("disc_redir_addr", MemAddr,             16'h0040);

        // Branch and DecodeReady together in HOLD.
        MemAck = 1'b1; MemData = 16'hABCD;
        tick();
        MemAck = 1'b0;
        check("f40_valid", {15'd0, InstrValid}, 16'h0001);
        check("f40_pcout", PcOut,               16'h0040);
        BranchTaken = 1'b1; BranchTarget = 16'h0100; DecodeReady = 1'b1;
        tick();
        BranchTaken = 1'b0; DecodeReady = 1'b0;
        check("hold_br_valid", {15'd0, InstrValid}, 16'h0000);
        check("hold_br_addr",  MemAddr,             16'h0100);

        // Branch with simultaneous ack in FETCH: data dropped, stay in FETCH.
        BranchTaken = 1'b1; BranchTarget = 16'hFFFF; MemAck = 1'b1; MemData = 16'h5555;
        tick();
        BranchTaken = 1'b0; MemAck = 1'b0;
        check("brack_valid", {15'd0, InstrValid}, 16'h0000);
        check("brack_req",   {15'd0, MemReq},     16'h0001);
        check("brack_addr",  MemAddr,             16'hFFFF);

        // Fetch at FFFF, PC wraps to 0.
        MemAck = 1'b1; MemData = 16'h7777;
        tick();
        MemAck = 1'b0;
        check("wrap_pcout", PcOut,    16'hFFFF);
        check("wrap_instr", InstrOut, 16'h7777);
        DecodeReady = 1'b1;
        tick();
        DecodeReady = 1'b0;
        check("wrap_addr", MemAddr, 16'h0000);

        // Two branches while the request drains: latest target wins.
        BranchTaken = 1'b1; BranchTarget = 16'h0200;
        tick();
        BranchTarget = 16'h0300;
        tick();
        BranchTaken = 1'b0;
        check("latest_hold_addr", MemAddr, 16'h0000);
        MemAck = 1'b1; MemData = 16'hBEEF;
        tick();
        MemAck = 1'b0;
        check("latest_addr", MemAddr, 16'h0300);

        // MemAck while in HOLD is ignored.
        MemAck = 1'b1; MemData = 16'h1111;
        tick();
        MemData = 16'h2222;
        tick();
        MemAck = 1'b0;
        check("ign_instr", InstrOut,            16'h1111);
        check("ign_pcout", PcOut,               16'h0300);
        check("ign_valid", {15'd0, InstrValid}, 16'h0001);
        check("ign_req",   {15'd0, MemReq},     16'h0000);

        // Asynchronous reset in the middle of DISCARD.
        DecodeReady = 1'b1;
        tick();
        DecodeReady = 1'b0;
        BranchTaken = 1'b1; BranchTarget = 16'h0777;
        tick();
        BranchTaken = 1'b0;
        check("pre_areset_req", {15'd0, MemReq}, 16'h0001);
        #2;
        Reset_n = 1'b0;
        #1;
        check("areset_req",   {15'd0, MemReq},     16'h0000);
        check("areset_valid", {15'd0, InstrValid}, 16'h0000);
        check("areset_addr",  MemAddr,             16'h0000);
        check("areset_instr", InstrOut,            16'h0000);
        @(negedge Clock);
        Reset_n = 1'b1;
        tick();
        check("refetch_req",  {15'd0, MemReq}, 16'h0001);
        check("refetch_addr", MemAddr,         16'h0000);

        // Branch taken during IDLE redirects the first fetch.
        Reset_n = 1'b0;
        tick();
        Reset_n = 1'b1;
        BranchTaken = 1'b1; BranchTarget = 16'h0A00;
        tick();
        BranchTaken = 1'b0;
        check("idle_br_req",  {15'd0, MemReq}, 16'h0001);
        check("idle_br_addr", MemAddr,         16'h0A00);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
